// File: rtl/mb_reg_pkg.sv
// Shared mailbox register map constants and initiator FSM encoding.
// Used by both the bus-side initiator and the register decoder.
package mb_reg_pkg;

  localparam int NUMBER_INTERFACE_REGS = 16;
  localparam int MB_REG_START          = 3;
  localparam int VERSION_REG_ADDR      = 15;
  localparam int CRC_ERROR_REG_ADDR    = 2;
  localparam int CMD_REG_0_ADDR        = 0;
  localparam int CMD_REG_1_ADDR        = 1;
  localparam int MB_REG_ADDR_W         = $clog2(NUMBER_INTERFACE_REGS);
  localparam int MB_REG_WAIT_CYCLES    = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_RESP
  } mb_reg_state_t;

endpackage

// File: rtl/mb_reg_addr_check.sv
// Combinational legality check and one-hot decode of a mailbox register index.
// Select stays all-zero for an illegal access so no strobe can leak out.
module mb_reg_addr_check
  import mb_reg_pkg::*;
#(
  parameter int N_REGS       = mb_reg_pkg::NUMBER_INTERFACE_REGS,
  parameter int REG_START    = mb_reg_pkg::MB_REG_START,
  parameter int VERSION_ADDR = mb_reg_pkg::VERSION_REG_ADDR,
  parameter int ADDR_W       = mb_reg_pkg::MB_REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              rwn,
  output logic              legal,
  output logic [N_REGS-1:0] select
);

  always_comb begin
    legal  = (int'(addr) >= REG_START) && (int'(addr) < N_REGS)
             && !(!rwn && (int'(addr) == VERSION_ADDR));
    select = '0;
    if (legal) select[addr] = 1'b1;
  end

endmodule

// File: rtl/mb_reg_initiator.sv
// Bus-side initiator for the mailbox register interface: one host request in
// flight, registered strobe toward the decoder, one response per request.
//
//  state     | meaning
//  ST_IDLE   | ready for a host request
//  ST_STROBE | select/rwn/wdata driven to decoder, wait counter running
//  ST_RESP   | response held until the host accepts it
module mb_reg_initiator
  import mb_reg_pkg::*;
#(
  parameter int NUMBER_INTERFACE_REGS = mb_reg_pkg::NUMBER_INTERFACE_REGS,
  parameter int MB_REG_START          = mb_reg_pkg::MB_REG_START,
  parameter int VERSION_REG_ADDR      = mb_reg_pkg::VERSION_REG_ADDR,
  parameter int WAIT_CYCLES           = mb_reg_pkg::MB_REG_WAIT_CYCLES,
  parameter int ADDR_W                = $clog2(NUMBER_INTERFACE_REGS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_rwn,
  input  logic [ADDR_W-1:0]                req_addr,
  input  logic [31:0]                      req_wdata,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [31:0]                      rsp_rdata,
  output logic                             rsp_err,
  output logic [NUMBER_INTERFACE_REGS-1:0] mb_reg_select,
  output logic                             mb_reg_rwn,
  output logic [31:0]                      mb_reg_wdata,
  input  logic [31:0]                      mb_reg_output
);

  mb_reg_state_t state, state_nxt;

  logic [3:0]                       cnt, cnt_nxt;
  logic                             addr_legal;
  logic [NUMBER_INTERFACE_REGS-1:0] sel_dec;
  logic [NUMBER_INTERFACE_REGS-1:0] select_nxt;
  logic                             rwn_nxt;
  logic [31:0]                      wdata_nxt;
  logic [31:0]                      rdata_nxt;
  logic                             err_nxt;

  mb_reg_addr_check #(
    .N_REGS       (NUMBER_INTERFACE_REGS),
    .REG_START    (MB_REG_START),
    .VERSION_ADDR (VERSION_REG_ADDR),
    .ADDR_W       (ADDR_W)
  ) u_addr_check (
    .addr   (req_addr),
    .rwn    (req_rwn),
    .legal  (addr_legal),
    .select (sel_dec)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    select_nxt = mb_reg_select;
    rwn_nxt    = mb_reg_rwn;
    wdata_nxt  = mb_reg_wdata;
    rdata_nxt  = rsp_rdata;
    err_nxt    = rsp_err;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          rdata_nxt = '0;
          if (addr_legal) begin
            state_nxt  = ST_STROBE;
            cnt_nxt    = 4'(WAIT_CYCLES);
            select_nxt = sel_dec;
            rwn_nxt    = req_rwn;
            wdata_nxt  = req_wdata;
            err_nxt    = 1'b0;
          end else begin
            state_nxt = ST_RESP;
            err_nxt   = 1'b1;
          end
        end
      end
      ST_STROBE: begin
        if (cnt == 4'd0) begin
          // mb_reg_rwn still holds the request direction on the final cycle
          if (mb_reg_rwn) rdata_nxt = mb_reg_output;
          state_nxt  = ST_RESP;
          select_nxt = '0;
          rwn_nxt    = 1'b1;
          wdata_nxt  = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
          rdata_nxt = '0;
          err_nxt   = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      mb_reg_select <= '0;
      mb_reg_rwn    <= 1'b1;
      mb_reg_wdata  <= '0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      mb_reg_select <= select_nxt;
      mb_reg_rwn    <= rwn_nxt;
      mb_reg_wdata  <= wdata_nxt;
      rsp_rdata     <= rdata_nxt;
      rsp_err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mb_reg_initiator.sv
// Directed bench for mb_reg_initiator: default wait (1) instance plus a
// zero-wait instance, with a small behavioural register decoder model.
module tb_mb_reg_initiator;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req_valid, req_ready, req_rwn;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [15:0] mb_reg_select;
  logic        mb_reg_rwn;
  logic [31:0] mb_reg_wdata, mb_reg_output;

  logic        req_valid0, req_ready0, req_rwn0;
  logic [3:0]  req_addr0;
  logic [31:0] req_wdata0;
  logic        rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] rsp_rdata0;
  logic [15:0] mb_reg_select0;
  logic        mb_reg_rwn0;
  logic [31:0] mb_reg_wdata0, mb_reg_output0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // decoder model: version register returns a fixed value, others echo select
  assign mb_reg_output  = (mb_reg_select  == 16'h8000) ? 32'h0001_0203 : {16'hBEEF, mb_reg_select};
  assign mb_reg_output0 = (mb_reg_select0 == 16'h8000) ? 32'h0001_0203 : {16'hBEEF, mb_reg_select0};

  mb_reg_initiator dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rwn(req_rwn),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mb_reg_select(mb_reg_select), .mb_reg_rwn(mb_reg_rwn),
    .mb_reg_wdata(mb_reg_wdata), .mb_reg_output(mb_reg_output)
  );

  mb_reg_initiator #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_rwn(req_rwn0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .mb_reg_select(mb_reg_select0), .mb_reg_rwn(mb_reg_rwn0),
    .mb_reg_wdata(mb_reg_wdata0), .mb_reg_output(mb_reg_output0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive a request for one cycle; returns in the first cycle after the accept edge
  task automatic issue(input logic rwn, input logic [3:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_rwn   = rwn;
    req_addr  = addr;
    req_wdata = wdata;
    check("accept_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 0; req_rwn = 1; req_addr = 0; req_wdata = 0; rsp_ready = 1;
    req_valid0 = 0; req_rwn0 = 1; req_addr0 = 0; req_wdata0 = 0; rsp_ready0 = 1;
    tick();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_select", mb_reg_select, 16'h0000);
    check("rst_rwn", mb_reg_rwn, 1);
    check("rst_wdata", mb_reg_wdata, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_ready", req_ready, 1);

    // read version register: 2-cycle strobe, response at T+3
    issue(1'b1, 4'd15, 32'h0);
    check("rd15_sel_c1", mb_reg_select, 16'h8000);
    check("rd15_rwn_c1", mb_reg_rwn, 1);
    check("rd15_ready_c1", req_ready, 0);
    check("rd15_valid_c1", rsp_valid, 0);
    tick();
    check("rd15_sel_c2", mb_reg_select, 16'h8000);
    check("rd15_valid_c2", rsp_valid, 0);
    tick();
    check("rd15_sel_off", mb_reg_select, 16'h0000);
    check("rd15_valid", rsp_valid, 1);
    check("rd15_rdata", rsp_rdata, 32'h0001_0203);
    check("rd15_err", rsp_err, 0);
    tick();
    check("rd15_done_valid", rsp_valid, 0);
    check("rd15_done_ready", req_ready, 1);

    // write addr 3
    issue(1'b0, 4'd3, 32'hDEAD_BEEF);
    check("wr3_sel_c1", mb_reg_select, 16'h0008);
    check("wr3_rwn_c1", mb_reg_rwn, 0);
    check("wr3_wdata_c1", mb_reg_wdata, 32'hDEAD_BEEF);
    tick();
    check("wr3_sel_c2", mb_reg_select, 16'h0008);
    check("wr3_rwn_c2", mb_reg_rwn, 0);
    check("wr3_wdata_c2", mb_reg_wdata, 32'hDEAD_BEEF);
    tick();
    check("wr3_valid", rsp_valid, 1);
    check("wr3_err", rsp_err, 0);
    check("wr3_rdata", rsp_rdata, 0);
    check("wr3_sel_off", mb_reg_select, 16'h0000);
    check("wr3_rwn_off", mb_reg_rwn, 1);
    tick();

    // illegal accesses: write version reg, read below MB_REG_START
    issue(1'b0, 4'd15, 32'h1234_5678);
    check("wr15_valid", rsp_valid, 1);
    check("wr15_err", rsp_err, 1);
    check("wr15_rdata", rsp_rdata, 0);
    check("wr15_sel", mb_reg_select, 16'h0000);
    check("wr15_rwn", mb_reg_rwn, 1);
    tick();
    check("wr15_ready", req_ready, 1);
    issue(1'b1, 4'd2, 32'h0);
    check("rd2_valid", rsp_valid, 1);
    check("rd2_err", rsp_err, 1);
    check("rd2_rdata", rsp_rdata, 0);
    check("rd2_sel", mb_reg_select, 16'h0000);
    tick();
    check("rd2_ready", req_ready, 1);

    // backpressure: read 14 with rsp_ready low, second request waits
    rsp_ready = 1'b0;
    issue(1'b1, 4'd14, 32'h0);
    tick();
    tick();
    req_valid = 1'b1; req_rwn = 1'b1; req_addr = 4'd5;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_rdata", rsp_rdata, 32'hBEEF_4000);
      check("bp_ready", req_ready, 0);
      check("bp_sel", mb_reg_select, 16'h0000);
      tick();
    end
    rsp_ready = 1'b1;
    check("bp_last_valid", rsp_valid, 1);
    tick();
    check("bp_idle_valid", rsp_valid, 0);
    check("bp_idle_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("rd5_sel", mb_reg_select, 16'h0020);
    tick();
    tick();
    check("rd5_valid", rsp_valid, 1);
    check("rd5_rdata", rsp_rdata, 32'hBEEF_0020);
    tick();

    // reset in the middle of a write strobe
    issue(1'b0, 4'd8, 32'h0BAD_F00D);
    check("wr8_sel", mb_reg_select, 16'h0100);
    check("wr8_rwn", mb_reg_rwn, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_sel", mb_reg_select, 16'h0000);
    check("rst_mid_rwn", mb_reg_rwn, 1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_ready", req_ready, 1);
      check("post_rst_valid", rsp_valid, 0);
      tick();
    end

    // zero-wait instance: single-cycle strobe, response at T+2
    req_valid0 = 1'b1; req_rwn0 = 1'b1; req_addr0 = 4'd4;
    check("w0_accept_ready", req_ready0, 1);
    tick();
    req_valid0 = 1'b0;
    check("w0_sel_c1", mb_reg_select0, 16'h0010);
    check("w0_valid_c1", rsp_valid0, 0);
    tick();
    check("w0_sel_off", mb_reg_select0, 16'h0000);
    check("w0_valid", rsp_valid0, 1);
    check("w0_rdata", rsp_rdata0, 32'hBEEF_0010);
    check("w0_err", rsp_err0, 0);
    tick();
    check("w0_done_ready", req_ready0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
